// File: rtl/block_coef_ctrl.sv
// Coefficient loader and FIFO/FIR gating for the 16-tap FIR path.
// Optional macro BLOCK_COEF_RELOAD_EN: a load request while in RUN restarts loading.
module block_coef_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [11:0] d,
  output logic [11:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module block_coef_ctrl (
  input  logic        clk_100MHz_i,
  input  logic        rst_i,
  input  logic        pulsador_carga_coef_i,
  input  logic        send_i,
  input  logic        full_fifo_i,
  input  logic        empty_i,
  input  logic [11:0] coef_in,
  input  logic        cambio_coef_i,
  output logic        led_full_o,
  output logic        wr_o,
  output logic        rd_o,
  output logic        en_fir_o,
  output logic [11:0] coef0,
  output logic [11:0] coef1,
  output logic [11:0] coef2,
  output logic [11:0] coef3,
  output logic [11:0] coef4,
  output logic [11:0] coef5,
  output logic [11:0] coef6,
  output logic [11:0] coef7,
  output logic [11:0] coef8,
  output logic [11:0] coef9,
  output logic [11:0] coef10,
  output logic [11:0] coef11,
  output logic [11:0] coef12,
  output logic [11:0] coef13,
  output logic [11:0] coef14,
  output logic [11:0] coef15
);
  localparam int NUM_TAPS = 16;
  localparam int COEF_W   = 12;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                             state, state_nxt;
  logic                               p1, p2, c1, c2, c3;
  logic                               req, stb, wr_en;
  logic [3:0]                         idx, idx_nxt;
  logic [NUM_TAPS-1:0]                we;
  logic [NUM_TAPS-1:0][COEF_W-1:0]    coef;

  // c3 only exists to turn the synchronized strobe into a one-cycle rising-edge pulse
  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      p1 <= 1'b0; p2 <= 1'b0;
      c1 <= 1'b0; c2 <= 1'b0; c3 <= 1'b0;
    end else begin
      p1 <= pulsador_carga_coef_i; p2 <= p1;
      c1 <= cambio_coef_i; c2 <= c1; c3 <= c2;
    end
  end

  assign req = p1 & p2;
  assign stb = c2 & ~c3;

  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_nxt = LOAD;
        idx_nxt   = '0;
      end
      LOAD: if (stb) begin
        wr_en   = 1'b1;
        idx_nxt = idx + 4'd1;
        if (idx == 4'd15) state_nxt = RUN;
      end
      RUN: begin
`ifdef BLOCK_COEF_RELOAD_EN
        if (req) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_lane
    assign we[i] = wr_en & (idx == 4'(i));
    block_coef_lane u_lane (
      .clk (clk_100MHz_i),
      .rst (rst_i),
      .we  (we[i]),
      .d   (coef_in),
      .q   (coef[i])
    );
  end

  assign en_fir_o = (state == RUN);

  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      wr_o       <= 1'b0;
      rd_o       <= 1'b0;
      led_full_o <= 1'b0;
    end else begin
      wr_o       <= (state == RUN) & ~full_fifo_i;
      rd_o       <= (state == RUN) & send_i & ~empty_i;
      led_full_o <= full_fifo_i;
    end
  end

  assign coef0  = coef[0];
  assign coef1  = coef[1];
  assign coef2  = coef[2];
  assign coef3  = coef[3];
  assign coef4  = coef[4];
  assign coef5  = coef[5];
  assign coef6  = coef[6];
  assign coef7  = coef[7];
  assign coef8  = coef[8];
  assign coef9  = coef[9];
  assign coef10 = coef[10];
  assign coef11 = coef[11];
  assign coef12 = coef[12];
  assign coef13 = coef[13];
  assign coef14 = coef[14];
  assign coef15 = coef[15];
endmodule

// File: tb/tb_block_coef_ctrl.sv
// Randomized bench for block_coef_ctrl against an edge-history reference model.
module tb_block_coef_ctrl;
  logic clk = 1'b0;
  logic rst, pb, send, full, empty, cs;
  logic [11:0] cin;
  logic led, wr, rd, en;
  logic [11:0] co [16];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  block_coef_ctrl dut (
    .clk_100MHz_i(clk), .rst_i(rst), .pulsador_carga_coef_i(pb), .send_i(send),
    .full_fifo_i(full), .empty_i(empty), .coef_in(cin), .cambio_coef_i(cs),
    .led_full_o(led), .wr_o(wr), .rd_o(rd), .en_fir_o(en),
    .coef0(co[0]), .coef1(co[1]), .coef2(co[2]), .coef3(co[3]),
    .coef4(co[4]), .coef5(co[5]), .coef6(co[6]), .coef7(co[7]),
    .coef8(co[8]), .coef9(co[9]), .coef10(co[10]), .coef11(co[11]),
    .coef12(co[12]), .coef13(co[13]), .coef14(co[14]), .coef15(co[15])
  );

  // Reference model: mode 0=idle 1=load 2=run; histories hold input samples k edges ago
  int          m_mode, m_idx;
  logic [11:0] m_coef [16];
  bit          m_wr, m_rd, m_led;
  bit          p_hist [1:3];
  bit          c_hist [1:3];
  bit          rand_fifo = 1'b0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] dut_vec();
    logic [191:0] v;
    for (int i = 0; i < 16; i++) v[i*12 +: 12] = co[i];
    return v;
  endfunction

  function automatic logic [191:0] mdl_vec();
    logic [191:0] v;
    for (int i = 0; i < 16; i++) v[i*12 +: 12] = m_coef[i];
    return v;
  endfunction

  task automatic model_edge();
    bit req, stb;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_wr = 0; m_rd = 0; m_led = 0;
      for (int i = 0; i < 16; i++) m_coef[i] = '0;
      for (int k = 1; k <= 3; k++) begin p_hist[k] = 0; c_hist[k] = 0; end
    end else begin
      req   = p_hist[1] && p_hist[2];          // request seen on two consecutive edges
      stb   = c_hist[2] && !c_hist[3];         // strobe rose two edges back
      m_wr  = (m_mode == 2) && !full;
      m_rd  = (m_mode == 2) && send && !empty;
      m_led = full;
      if (m_mode == 0) begin
        if (req) begin m_mode = 1; m_idx = 0; end
      end else if (m_mode == 1) begin
        if (stb) begin
          m_coef[m_idx] = cin;
          if (m_idx == 15) m_mode = 2;
          m_idx = (m_idx + 1) % 16;
        end
      end else begin
`ifdef BLOCK_COEF_RELOAD_EN
        if (req) begin m_mode = 1; m_idx = 0; end
`endif
      end
      p_hist[3] = p_hist[2]; p_hist[2] = p_hist[1]; p_hist[1] = pb;
      c_hist[3] = c_hist[2]; c_hist[2] = c_hist[1]; c_hist[1] = cs;
    end
  endtask

  task automatic cyc();
    if (rand_fifo) begin
      full  = 1'($urandom_range(0, 1));
      send  = 1'($urandom_range(0, 1));
      empty = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("en_fir", 192'(en),  192'(m_mode == 2));
    chk("wr",     192'(wr),  192'(m_wr));
    chk("rd",     192'(rd),  192'(m_rd));
    chk("led",    192'(led), 192'(m_led));
    chk("coefs",  dut_vec(), mdl_vec());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input int n);
    pb = 1'b1;
    repeat (n) cyc();
    pb = 1'b0;
  endtask

  task automatic strobe(input logic [11:0] v, input int hi, input int lo);
    cin = v; cs = 1'b1;
    repeat (hi) cyc();
    cs = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  int vals [16] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                    854, 376, -86, -156, 33, 136, 65, -99};

  initial begin
    rst = 1'b1; pb = 0; send = 0; full = 0; empty = 1; cs = 0; cin = '0;
    @(negedge clk);
    do_reset(138);
    chk("rst_coefs", dut_vec(), 192'd0);
    chk("rst_outs", 192'({en, wr, rd, led}), 192'd0);

    // Nominal load: 8680 ns strobe period
    press(2);
    idle(2);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("en_before_c15", 192'(en), 192'd0);
      strobe(12'(vals[i]), 434, 434);
    end
    chk("coef0",  192'(co[0]),  192'(12'hF9D));
    chk("coef4",  192'(co[4]),  192'(12'hF64));
    chk("coef7",  192'(co[7]),  192'(12'h356));
    chk("coef15", 192'(co[15]), 192'(12'hF9D));
    chk("en_run", 192'(en), 192'd1);

    // FIFO gating in RUN
    full = 1; send = 0; empty = 1;
    cyc();
    chk("wr_full", 192'(wr), 192'd0);
    chk("led_full", 192'(led), 192'd1);
    full = 0; send = 1; empty = 0;
    cyc();
    chk("rd_send", 192'(rd), 192'd1);
    chk("wr_free", 192'(wr), 192'd1);
    empty = 1;
    cyc();
    chk("rd_empty", 192'(rd), 192'd0);
    rand_fifo = 1'b1;
    idle(100);

`ifdef BLOCK_COEF_RELOAD_EN
    press(2);
    idle(2);
    strobe(12'h001, 3, 3);
    chk("reload_en", 192'(en), 192'd0);
    chk("reload_c0", 192'(co[0]), 192'(12'h001));
    chk("reload_c1", 192'(co[1]), 192'(12'd65));
`endif

    // Single-cycle press is ignored
    do_reset(2);
    idle(3);
    press(1);
    idle(3);
    for (int i = 0; i < 4; i++) strobe(12'($urandom), 2, 3);
    chk("short_press", dut_vec(), 192'd0);

    // Reset after seven coefficients
    press(2);
    idle(2);
    for (int i = 0; i < 7; i++) strobe(12'($urandom_range(1, 4095)), 2, 3);
    idle(2);
    do_reset(1);
    chk("midload_rst", dut_vec(), 192'd0);
    chk("midload_en", 192'(en), 192'd0);
    for (int i = 0; i < 3; i++) strobe(12'($urandom), 2, 3);
    chk("no_req_write", dut_vec(), 192'd0);

    // Randomized rounds, with stray presses and an occasional mid-load reset
    for (int r = 0; r < 8; r++) begin
      do_reset($urandom_range(1, 3));
      idle($urandom_range(0, 4));
      press($urandom_range(1, 4));
      idle($urandom_range(0, 3));
      for (int i = 0; i < 18; i++) begin
        if ($urandom_range(0, 9) == 0) pb = 1'b1;
        strobe(12'($urandom), $urandom_range(1, 6), $urandom_range(2, 6));
        pb = 1'b0;
        if (r == 5 && i == 9) do_reset(1);
      end
      idle(10);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/block_coef_ctrl.md
# block_coef_ctrl

Control and coefficient-storage block for the 16-tap FIR path. After a load request it captures sixteen 12-bit signed coefficients, one per rising edge of a slow strobe timed by the UART, into registers `coef0`..`coef15`. Once all sixteen are loaded it enables the filter and gates FIFO write and read strobes. It sits between the UART/FIFO front end and the FIR datapath.

## Interface
Parameters: none (16 taps and 12-bit width are fixed).
- `clk_100MHz_i`  in  1  system clock; all logic is on its rising edge.
- `rst_i`  in  1  reset. One clock; reset is synchronous and active-high.
- `pulsador_carga_coef_i`  in  1  load-request push-button, asynchronous level.
- `send_i`  in  1  downstream read request.
- `full_fifo_i`  in  1  FIFO full flag.
- `empty_i`  in  1  FIFO empty flag.
- `coef_in`  in  12  coefficient value, two's complement, stable while `cambio_coef_i` is high.
- `cambio_coef_i`  in  1  coefficient strobe, asynchronous. Each rising edge loads one coefficient.
- `led_full_o`  out  1  FIFO-full indicator.
- `wr_o`  out  1  FIFO write enable.
- `rd_o`  out  1  FIFO read enable.
- `en_fir_o`  out  1  FIR enable.
- `coef0`..`coef15`  out  12 each  stored coefficients, in load order.

## Operation
- Synchronizers:
  - `pulsador_carga_coef_i` passes through two flops, p1 then p2.
  - `cambio_coef_i` passes through three flops, c1, c2 and c3.
  - Strobe pulse = c2 & ~c3.
- States:
  - IDLE (reset state): strobe pulses are ignored. If p1 & p2 = 1, clear the index to 0 and go to LOAD. A 1-cycle press is ignored.
  - LOAD: on a strobe pulse, write `coef_in` to `coef[index]` and increment the 4-bit index. The pulse that writes index 15 moves the FSM to RUN on the same edge.
  - RUN: terminal until reset, unless the macro below is defined. Strobe pulses are ignored.
- `en_fir_o` = (state == RUN), decoded from the state register.
- `wr_o` = RUN & ~`full_fifo_i`, registered.
- `rd_o` = RUN & `send_i` & ~`empty_i`, registered.
- `led_full_o` is a registered copy of `full_fifo_i` in every state.
- Coefficients are stored as raw bits; there is no sign extension or saturation.
- Holding `pulsador_carga_coef_i` high while in LOAD or RUN has no effect.

## Timing
- Reset values: state IDLE, index 0, every `coefN` 0x000, all 1-bit outputs 0, all synchronizer flops 0.
- Reset has priority over every event on the same edge, including mid-load. A mid-load reset discards partially loaded values to 0.
- Load request: `pulsador_carga_coef_i` high before edge E1 produces LOAD after edge E3. It must be held at least 2 cycles.
- Coefficient write: with `cambio_coef_i` rising before edge E1, the write happens on E3. `coef_in` must be stable from E1 to E3.
- A strobe whose write edge (E3) falls while the FSM is in IDLE is not counted, even if the FSM moves to LOAD on that same edge.
- One write per rising edge of `cambio_coef_i`, however long the strobe stays high. The strobe must be low for at least 2 cycles between edges.
- `en_fir_o` rises on the same edge that writes `coef15`.
- `wr_o`, `rd_o` and `led_full_o` follow their inputs with 1 cycle of latency.
- The index does not wrap in LOAD; reaching 15 always exits to RUN.

## Configuration
- `BLOCK_COEF_RELOAD_EN` defined:
  - In RUN, p1 & p2 = 1 returns the FSM to LOAD with the index cleared.
  - `en_fir_o`, `wr_o` and `rd_o` drop while in LOAD.
  - Old coefficients are held until each one is overwritten.
- `BLOCK_COEF_RELOAD_EN` undefined: RUN is left only by `rst_i`.

## Test plan
- Reset held for 138 cycles → all `coefN` = 0x000; `en_fir_o`, `wr_o`, `rd_o`, `led_full_o` = 0.
- Pulsador held 2 cycles, then 16 strobes of 8680 ns each, carrying -99, 65, 136, 33, -156, -86, 376, 854, 854, 376, -86, -156, 33, 136, 65, -99 → `coef0` = 0xF9D, `coef4` = 0xF64, `coef7` = 0x356, `coef15` = 0xF9D. `en_fir_o` = 1 on the `coef15` write edge and not before.
- Pulsador high for a single cycle, then strobes → stays in IDLE and all `coefN` stay 0.
- In RUN: `full_fifo_i` = 1 → `wr_o` = 0 and `led_full_o` = 1 one cycle later. `send_i` = 1 with `empty_i` = 0 → `rd_o` = 1. `empty_i` = 1 → `rd_o` = 0.
- `rst_i` asserted after 7 coefficients are loaded → after the edge, index 0, all `coefN` = 0, IDLE. A fresh load request is required before any further write.
- With `BLOCK_COEF_RELOAD_EN` defined: in RUN, press pulsador and load 0x001 → `en_fir_o` = 0, `coef0` = 0x001, `coef1` keeps 65.
